// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter, direction per beat; optional parity via GRAY_CONV_PIPE_PARITY_EN.
// Latency: NUM_STAGES cycles from input acceptance to output valid; 1 beat/cycle sustained.
// Backpressure: valid/ready skid-free chain, empty stages collapse, full pipe deasserts data_in_ready_o.
module gray_conv_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  mode_i,
    input  logic                  data_in_valid_i,
    output logic                  data_in_ready_o,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  mode_o,
    output logic                  data_out_valid_o,
`ifdef GRAY_CONV_PIPE_PARITY_EN
    output logic                  parity_o,
`endif
    input  logic                  data_out_ready_i
);

    typedef struct packed {
        logic                  mode;
        logic [DATA_WIDTH-1:0] dat;
`ifdef GRAY_CONV_PIPE_PARITY_EN
        logic                  par;
`endif
    } beat_t;

    function automatic logic [DATA_WIDTH-1:0] gray_to_bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bin_to_gray(input logic [DATA_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    beat_t                 in_beat;
    beat_t                 stg_dat [NUM_STAGES];
    beat_t                 src_dat [NUM_STAGES];
    logic [NUM_STAGES-1:0] stg_vld;
    logic [NUM_STAGES-1:0] src_vld;
    logic [NUM_STAGES-1:0] stg_rdy;

    // Conversion is done before stage 0 so the XOR chain ends on a register.
    always_comb begin
        in_beat      = '0;
        in_beat.mode = mode_i;
        in_beat.dat  = mode_i ? bin_to_gray(data_in_i) : gray_to_bin(data_in_i);
`ifdef GRAY_CONV_PIPE_PARITY_EN
        in_beat.par  = ^data_in_i;
`endif
    end

    // A stage can load when it is empty or its contents move on this cycle.
    always_comb begin
        stg_rdy                = '0;
        stg_rdy[NUM_STAGES-1]  = !stg_vld[NUM_STAGES-1] || data_out_ready_i;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            stg_rdy[k] = !stg_vld[k] || stg_rdy[k+1];
        end
    end

    always_comb begin
        src_vld    = '0;
        src_vld[0] = data_in_valid_i;
        src_dat[0] = in_beat;
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_vld[k] = stg_vld[k-1];
            src_dat[k] = stg_dat[k-1];
        end
    end

    // Data only loads alongside a valid beat, so outputs hold while stalled or idle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stg_vld <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (stg_rdy[k]) begin
                    stg_vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        stg_dat[k] <= src_dat[k];
                    end
                end
            end
        end
    end

    assign data_in_ready_o  = stg_rdy[0];
    assign data_out_valid_o = stg_vld[NUM_STAGES-1];
    assign data_out_o       = stg_dat[NUM_STAGES-1].dat;
    assign mode_o           = stg_dat[NUM_STAGES-1].mode;
`ifdef GRAY_CONV_PIPE_PARITY_EN
    assign parity_o         = stg_dat[NUM_STAGES-1].par;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed and streaming checks of gray_conv_pipe with DATA_WIDTH=11, NUM_STAGES=3.
module tb_gray_conv_pipe;
    localparam int DW = 11;
    localparam int NS = 3;
    localparam int N_STREAM = 2048;

    logic          clk = 1'b0;
    logic          arst_ni;
    logic [DW-1:0] din;
    logic          mode_in;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] dout;
    logic          mode_out;
    logic          out_vld;
    logic          out_rdy;
`ifdef GRAY_CONV_PIPE_PARITY_EN
    logic          parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gray_conv_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
        .clk_i            (clk),
        .arst_ni          (arst_ni),
        .data_in_i        (din),
        .mode_i           (mode_in),
        .data_in_valid_i  (in_vld),
        .data_in_ready_o  (in_rdy),
        .data_out_o       (dout),
        .mode_o           (mode_out),
        .data_out_valid_o (out_vld),
`ifdef GRAY_CONV_PIPE_PARITY_EN
        .parity_o         (parity),
`endif
        .data_out_ready_i (out_rdy)
    );

    // Reference: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [DW-1:0] ref_g2b(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        for (int i = 0; i < DW; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [DW-1:0] ref_b2g(input logic [DW-1:0] b);
        logic [DW:0]   bx;
        logic [DW-1:0] g;
        bx = {1'b0, b};
        for (int i = 0; i < DW; i++) g[i] = bx[i] ^ bx[i+1];
        return g;
    endfunction

    task automatic test_reset();
        arst_ni = 1'b0; in_vld = 1'b0; din = '0; mode_in = 1'b0; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", out_vld); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL rst_data: got %h want 000", dout); end
        n_cmp++; if (mode_out !== 1'b0) begin n_err++; $display("FAIL rst_mode: got %b want 0", mode_out); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", in_rdy); end
        arst_ni = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL idle_vld: got %b want 0", out_vld); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL idle_data: got %h want 000", dout); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL idle_rdy: got %b want 1", in_rdy); end
    endtask

    task automatic test_latency();
        out_rdy = 1'b1; din = 11'h7FF; mode_in = 1'b0; in_vld = 1'b1;
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL lat_in_rdy: got %b want 1", in_rdy); end
        @(posedge clk); #1;
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_vld_e1: got %b want 0", out_vld); end
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_vld_e2: got %b want 0", out_vld); end
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL lat_vld_e3: got %b want 1", out_vld); end
        n_cmp++; if (dout !== 11'h555) begin n_err++; $display("FAIL lat_data: got %h want 555", dout); end
        n_cmp++; if (mode_out !== 1'b0) begin n_err++; $display("FAIL lat_mode: got %b want 0", mode_out); end
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_consumed: got %b want 0", out_vld); end
    endtask

    task automatic test_modes();
        logic [DW-1:0] vin  [3];
        logic          vmod [3];
        logic [DW-1:0] vexp [3];
        int            c;
        vin[0] = 11'h555; vmod[0] = 1'b1; vexp[0] = 11'h7FF;
        vin[1] = 11'h005; vmod[1] = 1'b1; vexp[1] = 11'h007;
        vin[2] = 11'h400; vmod[2] = 1'b0; vexp[2] = 11'h7FF;
        out_rdy = 1'b1;
        for (int v = 0; v < 3; v++) begin
            din = vin[v]; mode_in = vmod[v]; in_vld = 1'b1;
            @(posedge clk); #1;
            in_vld = 1'b0;
            c = 0;
            while (!out_vld && c < 8) begin
                @(posedge clk); #1;
                c++;
            end
            n_cmp++;
            if (!out_vld) begin
                n_err++; $display("FAIL mode_timeout[%0d]: got no valid want valid", v);
            end else if (dout !== vexp[v] || mode_out !== vmod[v]) begin
                n_err++;
                $display("FAIL mode_conv[%0d]: got %h/%b want %h/%b", v, dout, mode_out, vexp[v], vmod[v]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_q [4];
        int acc = 0;
        int got = 0;
        int cyc = 0;
        logic take;
        exp_q[0] = 11'h001; exp_q[1] = 11'h003; exp_q[2] = 11'h002; exp_q[3] = 11'h007;
        out_rdy = 1'b0; mode_in = 1'b0;
        while (acc < 4 && cyc < 8) begin
            din = DW'(acc + 1); in_vld = 1'b1;
            #1;
            if (!in_rdy) break;
            @(posedge clk); #1;
            acc++; cyc++;
        end
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepts: got %0d want 3", acc); end
        n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_rdy: got %b want 0", in_rdy); end
        for (int h = 0; h < 3; h++) begin
            n_cmp++;
            if (out_vld !== 1'b1 || dout !== 11'h001) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/001", h, out_vld, dout);
            end
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            #1;
            take = in_vld && in_rdy;
            if (out_vld) begin
                n_cmp++;
                if (dout !== exp_q[got]) begin
                    n_err++; $display("FAIL bp_order[%0d]: got %h want %h", got, dout, exp_q[got]);
                end
                got++;
            end
            @(posedge clk); #1;
            if (take) in_vld = 1'b0;
            cyc++;
        end
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL bp_drained: got %0d want 4", got); end
        in_vld = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL bp_extra: got %b want 0", out_vld); end
    endtask

    task automatic test_streaming();
        logic [DW:0]   sb [$];
        logic [DW:0]   e;
        logic [DW-1:0] want;
        int   sent = 0;
        int   passed = 0;
        int   cyc = 0;
        logic take;
        in_vld = 1'b0;
        din = DW'($urandom); mode_in = 1'($urandom);
        while ((sent < N_STREAM || sb.size() != 0) && cyc < 20000) begin
            if (!in_vld && sent < N_STREAM) in_vld = ($urandom_range(0, 3) != 0);
            out_rdy = 1'($urandom_range(0, 1));
            #1;
            take = in_vld && in_rdy;
            if (out_vld && out_rdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious: got %h want none", dout);
                end else begin
                    e = sb.pop_front();
                    if (dout === e[DW-1:0] && mode_out === e[DW]) passed++;
                    else begin
                        n_err++;
                        $display("FAIL stream_beat: got %h/%b want %h/%b", dout, mode_out, e[DW-1:0], e[DW]);
                    end
                end
            end
            if (take) begin
                want = mode_in ? ref_b2g(din) : ref_g2b(din);
                sb.push_back({mode_in, want});
                sent++;
            end
            @(posedge clk); #1;
            if (take) begin
                in_vld = 1'b0;
                din = DW'($urandom); mode_in = 1'($urandom);
            end
            cyc++;
        end
        in_vld = 1'b0;
        n_cmp++; if (passed !== N_STREAM) begin n_err++; $display("FAIL stream_pass: got %0d want %0d", passed, N_STREAM); end
    endtask

    task automatic test_midflight_reset();
        logic seen = 1'b0;
        out_rdy = 1'b0; mode_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            din = DW'(b + 9); in_vld = 1'b1;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL mr_pre_vld: got %b want 1", out_vld); end
        #2 arst_ni = 1'b0;
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL mr_async_vld: got %b want 0", out_vld); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL mr_async_data: got %h want 000", dout); end
        repeat (2) @(posedge clk);
        #1 arst_ni = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_vld) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mr_ghost: got beat want none"); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_modes();
        test_backpressure();
        test_streaming();
        test_midflight_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gray_conv_pipe.md
Name: gray_conv_pipe

Overview:
Pipelined, bidirectional Gray/binary code converter with a valid/ready handshake on both sides. It is the sequential successor to the combinational gray-to-binary converter. The conversion direction is selectable per transaction, and the data width and pipeline depth are parametrised. It sits in clock-domain-crossing pointer paths and encoder datapaths where the XOR-chain delay must be registered and backpressure must be honoured.

Parameters:
DATA_WIDTH, 8, width of the data in and out.
NUM_STAGES, 2, number of register stages between input and output; legal range 1..8.

Ports:
clk_i  input  1  clock; all logic rising-edge.
arst_ni  input  1  asynchronous active-low reset.
data_in_i  input  DATA_WIDTH  operand.
mode_i  input  1  0 = gray-to-binary, 1 = binary-to-gray; sampled with data_in_i.
data_in_valid_i  input  1  input beat valid.
data_in_ready_o  output  1  block can accept an input beat.
data_out_o  output  DATA_WIDTH  converted result.
mode_o  output  1  mode carried alongside the result.
data_out_valid_o  output  1  output beat valid.
data_out_ready_i  input  1  downstream accepts the output beat.

Behaviour:
- Reset: async assert clears every stage valid bit and stage data/mode to 0. data_out_o = 0, mode_o = 0, data_out_valid_o = 0, data_in_ready_o = 1 while reset is held and after release.
- Reset mid-operation: all in-flight beats are discarded. No beat appears at the output after reset deassertion unless it was accepted after deassertion.
- Input handshake: a beat transfers when data_in_valid_i && data_in_ready_o on a rising edge.
- Output handshake: a beat transfers when data_out_valid_o && data_out_ready_i.
- Conversion happens combinationally on accepted input, then the result is registered into stage 0:
  - gray-to-binary: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - binary-to-gray: g = b ^ (b >> 1).
- Stage k (k = 0..NUM_STAGES-1) holds valid_k, data_k, mode_k. The last stage drives the outputs.
- Stage k loads from stage k-1 (or from the input for k = 0) when the stage is empty or is being drained this cycle. Empty stages collapse as bubbles.
- data_in_ready_o = !valid_0 || stage 0 drains this cycle. It is combinational and may depend on data_out_ready_i through the ready chain.
- Latency: exactly NUM_STAGES cycles from input acceptance to data_out_valid_o with no backpressure.
- Throughput: 1 beat/cycle sustained when data_out_ready_i = 1.
- Backpressure: with data_out_ready_i = 0, the pipeline fills to NUM_STAGES beats, then data_in_ready_o = 0.
  - data_out_o and mode_o stay stable while valid && !ready.
  - No beat is lost or duplicated. Order is preserved.
- Simultaneous full + drain + accept in one cycle: the whole pipeline shifts and a new beat enters stage 0.
- Mixed modes in flight are legal. Each beat is converted per its own mode_i.

Optional Feature:
Macro GRAY_CONV_PIPE_PARITY_EN.
- Defined: adds output parity_o (1 bit) = XOR-reduction of data_in_i at acceptance, carried through the pipeline aligned with data_out_o. parity_o resets to 0.
- Not defined: port and registers are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold arst_ni = 0 for 3 cycles, release -> data_out_valid_o = 0, data_out_o = 0, data_in_ready_o = 1.
- Latency, DATA_WIDTH = 11, NUM_STAGES = 3: accept gray 11'h7FF mode 0 with ready = 1 -> 3 cycles later valid = 1, data_out_o = 11'h555, mode_o = 0.
- Reverse mode: binary 11'h555 mode 1 -> 11'h7FF. Binary 11'h005 -> 11'h007. Gray 11'h400 mode 0 -> 11'h7FF.
- Backpressure: ready = 0, push 4 beats (0x001, 0x002, 0x003, 0x004, mode 0).
  - data_in_ready_o = 0 after 3 accepts.
  - Output holds 0x001 stable.
  - Release ready -> outputs 0x001, 0x003, 0x002, 0x007 in order, no loss.
- Streaming: 2^11 random beats with random mode and random ready -> all results match the reference model in order, with pass count = 2048.
- Mid-flight reset: 2 beats in flight, pulse arst_ni low -> valid drops asynchronously and neither beat ever emerges.
